opfetch_stage: RTL and testbench
================================

# opfetch_stage

Operand-fetch pipeline stage sitting directly downstream of the register file. It accepts decoded instructions from decode, drives the register-file read addresses, and captures the two source operands into an output pipeline register for execute. It keeps a per-register scoreboard of in-flight writes so that no instruction leaves with a stale operand. Optionally, it forwards the same-cycle writeback value.

## Interface
- ADDR_SIZE, 5, register address width; register file holds 2**ADDR_SIZE entries.
- WORD_SIZE, 32, operand/data width.

- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  stage accepts the instruction this cycle.
- in_rs1  input  ADDR_SIZE  source register 1.
- in_rs2  input  ADDR_SIZE  source register 2.
- in_rd  input  ADDR_SIZE  destination register.
- in_rd_we  input  1  instruction writes in_rd.
- raddr1  output  ADDR_SIZE  register-file read address 1; equals in_rs1.
- raddr2  output  ADDR_SIZE  register-file read address 2; equals in_rs2.
- rdata1  input  WORD_SIZE  register-file read data 1 (combinational).
- rdata2  input  WORD_SIZE  register-file read data 2 (combinational).
- wb_en  input  1  writeback strobe; the same signal drives the register-file w_en.
- wb_addr  input  ADDR_SIZE  writeback register.
- wb_data  input  WORD_SIZE  writeback data.
- out_valid  output  1  execute-side instruction valid.
- out_ready  input  1  execute accepts the instruction.
- out_op1  output  WORD_SIZE  captured operand 1.
- out_op2  output  WORD_SIZE  captured operand 2.
- out_rd  output  ADDR_SIZE  captured destination register.
- out_rd_we  output  1  captured write enable.

## Operation
- Scoreboard state: pending[2**ADDR_SIZE-1:0], one bit per register.
- Register 0 is never pending. A source address of 0 always yields operand value 0.
- clear_hit(r) = wb_en && wb_addr==r && r!=0.
- blocked(r) = pending[r] && !(BYPASS && clear_hit(r)), where BYPASS is 1 only when OPFETCH_BYPASS_EN is defined.
- hazard = blocked(in_rs1) || blocked(in_rs2) || (in_rd_we && in_rd!=0 && blocked(in_rd)).
  - The in_rd term is the WAW check: at most one write per register is in flight.
- in_ready = rst_n && (!out_valid || out_ready) && !hazard. It is combinational and does not depend on in_valid.
- Issue: a transfer occurs when in_valid && in_ready. On a transfer the output register loads:
  - out_op1 = 0 if in_rs1==0; otherwise wb_data if BYPASS && clear_hit(in_rs1); otherwise rdata1.
  - out_op2 is selected the same way from in_rs2 and rdata2.
  - out_rd and out_rd_we are copied from in_rd and in_rd_we.
  - out_valid is set to 1.
- Drain: if there is no transfer and out_ready is high, out_valid goes to 0. The data fields hold their values.
- Hold: while out_valid && !out_ready, all out_* fields stay stable.
- Scoreboard update, every cycle:
  - pending[wb_addr] is cleared if wb_en is high.
  - pending[in_rd] is then set on a transfer with in_rd_we && in_rd!=0.
  - If both hit the same register, set wins.
- wb_en to a register that is not pending is legal. It clears nothing and the write still lands in the register file.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N is on out_* after edge N.
- Throughput: 1 instruction per cycle when hazard-free and out_ready is high.
- Writeback-to-use:
  - With bypass: a dependent instruction issues in the same cycle that wb_en clears its source.
  - Without bypass: it issues one cycle after the wb_en cycle, once the register file holds the new value.
- Reset (rst_n low at an edge): out_valid=0, out_op1=0, out_op2=0, out_rd=0, out_rd_we=0, and all pending bits are 0.
  - in_ready is 0 while rst_n is low.
  - A reset mid-operation discards the held instruction and all scoreboard state.

## Configuration
- OPFETCH_BYPASS_EN defined: same-cycle forwarding from wb_data into the operand capture, with the matching relaxation in blocked().
- OPFETCH_BYPASS_EN undefined: no forwarding path. A source register stays blocked during the wb_en cycle and operands always come from rdata1 and rdata2, or 0 for register 0.

## Test plan
- Reset, then issue rs1=1, rs2=2 with the register file holding x1=0x11 and x2=0x22, out_ready=1 -> the next cycle shows out_valid=1, out_op1=0x11, out_op2=0x22.
- Issue rd=5 with rd_we=1, then an instruction with rs1=5 -> in_ready=0 until wb_en with wb_addr=5, wb_data=0xABCD.
  - Bypass build: it issues that same cycle with out_op1=0xABCD.
  - Non-bypass build: it issues one cycle later with out_op1=0xABCD.
- rs1=0 and rs2=0 while the register-file entry 0 reads 0xFFFFFFFF -> out_op1=0 and out_op2=0. rd=0 with rd_we=1 never sets pending.
- Hold out_ready=0 for 3 cycles with out_valid=1 -> out_* stay stable and in_ready=0. Raise out_ready -> the queued instruction transfers on the next edge.
- WAW: with rd=7 pending, an instruction with rd=7 and rd_we=1 has in_ready=0 until wb_addr=7 clears pending[7]. In the bypass build it issues in the clear cycle and pending[7] stays 1.
- Drive rst_n=0 for one edge while out_valid=1 and pending[3]=1 -> out_valid=0 and all pending bits 0. An instruction reading x3 then issues immediately.

Source files
------------

// File: rtl/opfetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : opfetch_stage
// Description : Operand-fetch stage with a per-register write scoreboard.
//               Define OPFETCH_BYPASS_EN to forward same-cycle writeback data.
// Revision    : 1.0 - initial release
// ============================================================================
module opfetch_stage #(
    parameter int ADDR_SIZE = 5,
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ADDR_SIZE-1:0] in_rs1,
    input  logic [ADDR_SIZE-1:0] in_rs2,
    input  logic [ADDR_SIZE-1:0] in_rd,
    input  logic                 in_rd_we,
    output logic [ADDR_SIZE-1:0] raddr1,
    output logic [ADDR_SIZE-1:0] raddr2,
    input  logic [WORD_SIZE-1:0] rdata1,
    input  logic [WORD_SIZE-1:0] rdata2,
    input  logic                 wb_en,
    input  logic [ADDR_SIZE-1:0] wb_addr,
    input  logic [WORD_SIZE-1:0] wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_op1,
    output logic [WORD_SIZE-1:0] out_op2,
    output logic [ADDR_SIZE-1:0] out_rd,
    output logic                 out_rd_we
);

    localparam int c_NUM_REGS = 2 ** ADDR_SIZE;

    logic [c_NUM_REGS-1:0] r_pending;
    logic [c_NUM_REGS-1:0] w_pending_nxt;
    logic                  r_out_valid;
    logic [WORD_SIZE-1:0]  r_out_op1;
    logic [WORD_SIZE-1:0]  r_out_op2;
    logic [ADDR_SIZE-1:0]  r_out_rd;
    logic                  r_out_rd_we;

    logic w_fwd_rs1, w_fwd_rs2, w_fwd_rd;
    logic w_blk_rs1, w_blk_rs2, w_blk_rd;
    logic w_hazard, w_xfer, w_ready;
    logic [WORD_SIZE-1:0] w_op1, w_op2;

    assign raddr1 = in_rs1;
    assign raddr2 = in_rs2;

`ifdef OPFETCH_BYPASS_EN
    // A register being written back this cycle is usable now via wb_data.
    assign w_fwd_rs1 = wb_en && (wb_addr == in_rs1) && (in_rs1 != '0);
    assign w_fwd_rs2 = wb_en && (wb_addr == in_rs2) && (in_rs2 != '0);
    assign w_fwd_rd  = wb_en && (wb_addr == in_rd)  && (in_rd  != '0);
`else
    assign w_fwd_rs1 = 1'b0;
    assign w_fwd_rs2 = 1'b0;
    assign w_fwd_rd  = 1'b0;
`endif

    assign w_blk_rs1 = r_pending[in_rs1] && !w_fwd_rs1;
    assign w_blk_rs2 = r_pending[in_rs2] && !w_fwd_rs2;
    assign w_blk_rd  = r_pending[in_rd]  && !w_fwd_rd;

    assign w_hazard = w_blk_rs1 || w_blk_rs2 ||
                      (in_rd_we && (in_rd != '0) && w_blk_rd);
    assign w_ready  = rst_n && (!r_out_valid || out_ready) && !w_hazard;
    assign w_xfer   = in_valid && w_ready;

    always_comb begin
        w_op1 = rdata1;
        if (in_rs1 == '0)
            w_op1 = '0;
        else if (w_fwd_rs1)
            w_op1 = wb_data;
    end

    always_comb begin
        w_op2 = rdata2;
        if (in_rs2 == '0)
            w_op2 = '0;
        else if (w_fwd_rs2)
            w_op2 = wb_data;
    end

    // Clear first so that a same-register issue in the clear cycle re-arms it.
    always_comb begin
        w_pending_nxt = r_pending;
        if (wb_en)
            w_pending_nxt[wb_addr] = 1'b0;
        if (w_xfer && in_rd_we && (in_rd != '0))
            w_pending_nxt[in_rd] = 1'b1;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending   <= '0;
            r_out_valid <= 1'b0;
            r_out_op1   <= '0;
            r_out_op2   <= '0;
            r_out_rd    <= '0;
            r_out_rd_we <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_op1   <= w_op1;
                r_out_op2   <= w_op2;
                r_out_rd    <= in_rd;
                r_out_rd_we <= in_rd_we;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign out_op1   = r_out_op1;
    assign out_op2   = r_out_op2;
    assign out_rd    = r_out_rd;
    assign out_rd_we = r_out_rd_we;

endmodule
`default_nettype wire

// File: tb/tb_opfetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_opfetch_stage
// Description : Directed self-checking bench for opfetch_stage (either build
//               of OPFETCH_BYPASS_EN), with a behavioural register file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_opfetch_stage;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_rd_we;
    logic [AW-1:0] in_rs1, in_rs2, in_rd;
    logic [AW-1:0] raddr1, raddr2;
    logic [DW-1:0] rdata1, rdata2;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          out_valid, out_ready, out_rd_we;
    logic [DW-1:0] out_op1, out_op2;
    logic [AW-1:0] out_rd;

    logic [DW-1:0] rf [0:(1<<AW)-1];
    int n_checks = 0;
    int n_errors = 0;

`ifdef OPFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    opfetch_stage #(.ADDR_SIZE(AW), .WORD_SIZE(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2),
        .out_rd(out_rd), .out_rd_we(out_rd_we)
    );

    always #5 clk = ~clk;

    assign rdata1 = rf[raddr1];
    assign rdata2 = rf[raddr2];
    always @(posedge clk) if (wb_en) rf[wb_addr] <= wb_data;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are driven 1ns after the edge; combinational outputs are read 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic we);
        in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = we;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1<<AW); i++) rf[i] = 32'h100 + i;
        rf[0] = 32'hFFFF_FFFF;
        rf[1] = 32'h11;
        rf[2] = 32'h22;
        rst_n = 1'b0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

        // Reset state
        tick(); tick();
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
        settle();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_op1", out_op1, 0);
        check_eq("rst_out_op2", out_op2, 0);
        check_eq("rst_out_rd_we", out_rd_we, 0);
        check_eq("rst_in_ready", in_ready, 0);

        // Basic issue: rs1=1 rs2=2 rd=5
        rst_n = 1'b1;
        settle();
        check_eq("basic_in_ready", in_ready, 1);
        check_eq("basic_raddr1", raddr1, 1);
        tick();
        check_eq("basic_out_valid", out_valid, 1);
        check_eq("basic_op1", out_op1, 32'h11);
        check_eq("basic_op2", out_op2, 32'h22);
        check_eq("basic_rd", out_rd, 5);
        check_eq("basic_rd_we", out_rd_we, 1);

        // RAW on x5
        drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b0);
        settle();
        check_eq("raw_blocked0", in_ready, 0);
        tick();
        check_eq("raw_drain", out_valid, 0);
        check_eq("raw_blocked1", in_ready, 0);
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hABCD;
        settle();
        check_eq("raw_wb_cycle_ready", in_ready, BYP);
        tick();
        wb_en = 1'b0;
        if (!BYP) begin
            settle();
            check_eq("raw_after_wb_ready", in_ready, 1);
            tick();
        end
        check_eq("raw_out_valid", out_valid, 1);
        check_eq("raw_op1", out_op1, 32'hABCD);
        check_eq("raw_op2_zero", out_op2, 0);

        // Register 0: reads 0, never pending
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        settle();
        check_eq("x0_in_ready", in_ready, 1);
        tick();
        check_eq("x0_op1", out_op1, 0);
        check_eq("x0_op2", out_op2, 0);
        check_eq("x0_rd_we", out_rd_we, 1);
        settle();
        check_eq("x0_not_pending", in_ready, 1);

        // Backpressure hold
        drive(1'b1, 5'd1, 5'd2, 5'd9, 1'b0);
        tick();
        check_eq("hold_load_op1", out_op1, 32'h11);
        out_ready = 1'b0;
        drive(1'b1, 5'd2, 5'd1, 5'd10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq("hold_in_ready", in_ready, 0);
            tick();
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_op1", out_op1, 32'h11);
            check_eq("hold_op2", out_op2, 32'h22);
            check_eq("hold_rd", out_rd, 9);
        end
        out_ready = 1'b1;
        settle();
        check_eq("hold_release_ready", in_ready, 1);
        tick();
        check_eq("hold_next_op1", out_op1, 32'h22);
        check_eq("hold_next_op2", out_op2, 32'h11);
        check_eq("hold_next_rd", out_rd, 10);

        // WAW on x7
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
        tick();
        drive(1'b1, 5'd1, 5'd2, 5'd7, 1'b1);
        settle();
        check_eq("waw_blocked0", in_ready, 0);
        tick();
        check_eq("waw_blocked1", in_ready, 0);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
        settle();
        check_eq("waw_clear_cycle_ready", in_ready, BYP);
        tick();
        wb_en = 1'b0;
        if (!BYP) begin
            settle();
            check_eq("waw_after_clear_ready", in_ready, 1);
            tick();
        end
        check_eq("waw_issued_rd", out_rd, 7);
        drive(1'b1, 5'd7, 5'd0, 5'd8, 1'b0);
        settle();
        check_eq("waw_rearmed", in_ready, 0);
        in_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h78;
        tick();
        wb_en = 1'b0;
        // Writeback to a non-pending register is harmless
        wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'hC0DE;
        tick();
        wb_en = 1'b0;
        drive(1'b1, 5'd12, 5'd7, 5'd0, 1'b0);
        settle();
        check_eq("wb_nonpending_ready", in_ready, 1);
        tick();
        check_eq("wb_nonpending_op1", out_op1, 32'hC0DE);
        check_eq("wb_nonpending_op2", out_op2, 32'h78);

        // Reset mid-operation
        drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1);
        tick();
        check_eq("mid_pre_valid", out_valid, 1);
        in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
        tick();
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_rd", out_rd, 0);
        rst_n = 1'b1; out_ready = 1'b1;
        drive(1'b1, 5'd3, 5'd0, 5'd4, 1'b0);
        settle();
        check_eq("mid_rst_x3_ready", in_ready, 1);
        tick();
        check_eq("mid_rst_x3_op1", out_op1, 32'h103);
        in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
